// File: rtl/mat_serializer_pkg.sv
// rtl/mat_serializer_pkg.sv - shared config for mat_serializer
// Purpose: PORT_2D packed-matrix width macro, FSM state type, index width
//          and element offset helpers used by mat_serializer and
//          mat_index_counter.
// Ports:   none (package).
`ifndef MAT_SERIALIZER_PKG_SV
`define MAT_SERIALIZER_PKG_SV

// Packed range of a d1 x d2 matrix of w-bit elements.
`define PORT_2D(d1, d2, w) [(d1)*(d2)*(w)-1:0]

package mat_serializer_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_t;

    // Width of a 1-based index that must be able to hold the value n.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bit offset of 1-based element (i,j) in a PORT_2D packed matrix.
    function automatic int elem_offset(input int i, input int j, input int d2, input int w);
        return ((i - 1) * d2 + (j - 1)) * w;
    endfunction

endpackage

`endif

// File: rtl/mat_serializer_index_counter.sv
// rtl/mat_serializer_index_counter.sv - 1-based row/column walker with last flag
// Purpose: two wrapping 1-based counters (row 1..D1, column 1..D2) stepped by
//          advance and reset to (1,1) by load. last is registered with the
//          indices and is high when they point at (D1,D2).
//          Macro MAT_SER_TRANSPOSE_EN selects column-major order (row index
//          runs fastest); otherwise row-major (column index runs fastest).
// Ports:   clk, rst (sync active-high), load, advance,
//          row [idx_width(D1)], col [idx_width(D2)], last.
module mat_index_counter
    import mat_serializer_pkg::*;
#(
    parameter int D1 = 3,
    parameter int D2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     advance,
    output logic [idx_width(D1)-1:0] row,
    output logic [idx_width(D2)-1:0] col,
    output logic                     last
);

    localparam int RW = idx_width(D1);
    localparam int CW = idx_width(D2);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [RW-1:0] ROW_MAX = RW'(D1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [CW-1:0] COL_MAX = CW'(D2);

    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (load) begin
            row_nxt = ROW_ONE;
            col_nxt = COL_ONE;
        end else if (advance) begin
`ifdef MAT_SER_TRANSPOSE_EN
            if (row < ROW_MAX) begin
                row_nxt = row + ROW_ONE;
            end else begin
                row_nxt = ROW_ONE;
                col_nxt = (col < COL_MAX) ? col + COL_ONE : COL_ONE;
            end
`else
            if (col < COL_MAX) begin
                col_nxt = col + COL_ONE;
            end else begin
                col_nxt = COL_ONE;
                row_nxt = (row < ROW_MAX) ? row + ROW_ONE : ROW_ONE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row  <= ROW_ONE;
            col  <= COL_ONE;
            last <= 1'b0;
        end else begin
            row  <= row_nxt;
            col  <= col_nxt;
            // Computed from the next indices so last lines up with them.
            last <= (row_nxt == ROW_MAX) && (col_nxt == COL_MAX);
        end
    end

endmodule

// File: rtl/mat_serializer.sv
// rtl/mat_serializer.sv - packed matrix to element stream serializer
// Purpose: captures one PORT_2D packed D1 x D2 matrix on an in_valid/in_ready
//          handshake, then emits its elements one per out_valid/out_ready
//          handshake with 1-based (row,col) tags and out_last on (D1,D2).
//          Macro MAT_SER_TRANSPOSE_EN switches emission to column-major.
// Ports:   clk, rst (sync active-high),
//          in_valid, in_ready, mat_in [D1*D2*bitlength],
//          out_valid, out_ready, out_data [bitlength],
//          out_row [$clog2(D1+1)], out_col [$clog2(D2+1)], out_last, busy.
module mat_serializer
    import mat_serializer_pkg::*;
#(
    parameter int bitlength = 8,
    parameter int D1        = 3,
    parameter int D2        = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic `PORT_2D(D1, D2, bitlength)       mat_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [bitlength-1:0]                   out_data,
    output logic [idx_width(D1)-1:0]               out_row,
    output logic [idx_width(D2)-1:0]               out_col,
    output logic                                   out_last,
    output logic                                   busy
);

    ser_state_t state;
    ser_state_t state_nxt;

    logic `PORT_2D(D1, D2, bitlength) mat_q;
    logic                             cnt_last;
    logic                             accept;
    logic                             advance;

    assign accept  = in_valid && in_ready;
    assign advance = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_STREAM;
            ST_STREAM: if (advance && out_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic; in_ready is forced low while rst is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Matrix is frozen after capture so mat_in may change freely upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q <= '0;
        end else if (accept) begin
            mat_q <= mat_in;
        end
    end

    mat_index_counter #(
        .D1(D1),
        .D2(D2)
    ) u_index (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .advance(advance),
        .row    (out_row),
        .col    (out_col),
        .last   (cnt_last)
    );

    // The counter's last flag persists into IDLE for a 1x1 matrix, so it is
    // qualified by the stream state.
    assign out_last = cnt_last && (state == ST_STREAM);

    // Element select as a mux over constant offsets.
    always_comb begin
        out_data = '0;
        for (int i = 1; i <= D1; i++) begin
            for (int j = 1; j <= D2; j++) begin
                if ((int'(out_row) == i) && (int'(out_col) == j)) begin
                    out_data = mat_q[elem_offset(i, j, D2, bitlength) +: bitlength];
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_serializer.sv
// tb/tb_mat_serializer.sv - scoreboard bench for mat_serializer
`timescale 1ns/1ps
module tb_mat_serializer;

    localparam int BL = 8;
    localparam int D1 = 4;
    localparam int D2 = 3;
    localparam int N  = D1 * D2;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] row;
        logic [1:0] col;
        logic       last;
    } elem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*BL-1:0] mat_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_data;
    logic [2:0]      out_row;
    logic [1:0]      out_col;
    logic            out_last;
    logic            busy;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [7:0] mat_in1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b1;
    logic [7:0] out_data1;
    logic [0:0] out_row1;
    logic [0:0] out_col1;
    logic       out_last1;
    logic       busy1;

    mat_serializer #(.bitlength(BL), .D1(D1), .D2(D2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mat_in(mat_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy)
    );

    mat_serializer #(.bitlength(8), .D1(1), .D2(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .mat_in(mat_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_row(out_row1), .out_col(out_col1),
        .out_last(out_last1), .busy(busy1)
    );

    int    checks = 0;
    int    errors = 0;
    elem_t exp_q[$];
    logic [7:0] cur [D1][D2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: emission order straight from the matrix indices.
    task automatic push_expected();
        elem_t e;
`ifdef MAT_SER_TRANSPOSE_EN
        for (int j = 0; j < D2; j++)
            for (int i = 0; i < D1; i++) begin
`else
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D2; j++) begin
`endif
                e.data = cur[i][j];
                e.row  = 3'(i + 1);
                e.col  = 2'(j + 1);
                e.last = (i == D1 - 1) && (j == D2 - 1);
                exp_q.push_back(e);
            end
    endtask

    function automatic logic [N*BL-1:0] pack_cur();
        logic [N*BL-1:0] p;
        p = '0;
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D2; j++)
                p[(i * D2 + j) * BL +: BL] = cur[i][j];
        return p;
    endfunction

    task automatic randomize_cur();
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D2; j++)
                cur[i][j] = 8'($urandom_range(0, 255));
    endtask

    task automatic load_plan();
        int v [12];
        v = '{60, 69, 78, 99, 114, 129, 138, 159, 180, 177, 204, 231};
        for (int k = 0; k < N; k++) cur[k / D2][k % D2] = 8'(v[k]);
    endtask

    task automatic send_cur();
        logic [N*BL-1:0] p;
        bit ok;
        p = pack_cur();
        mat_in   = p;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        push_expected();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mat_in   = ~p;
        @(negedge clk);
        check("first_valid_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input bit rand_ready);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_queue_at(input int n);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (exp_q.size() == n) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("queue_wait_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    elem_t snap;
    bit    stalled    = 1'b0;
    bit    after_last = 1'b0;
    initial begin
        elem_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled    = 1'b0;
                after_last = 1'b0;
                continue;
            end
            check("busy_eq_valid", 32'(busy), 32'(out_valid));
            if (after_last) begin
                check("in_ready_after_last", 32'(in_ready), 32'd1);
                after_last = 1'b0;
            end
            if (stalled) begin
                check("stall_valid_held", 32'(out_valid), 32'd1);
                check("stall_outputs_held", 32'({out_data, out_row, out_col, out_last}), 32'(snap));
            end
            if (out_valid && !out_ready) begin
                if (!stalled) snap = {out_data, out_row, out_col, out_last};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("element", 32'({out_data, out_row, out_col, out_last}), 32'(e));
                end
                if (out_last) after_last = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd1);
        check("rst_out_col", 32'(out_col), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed matrix, full throughput
        load_plan();
        send_cur();
        drain(1'b0);

        // Same matrix, 3-cycle stall on the third element
        send_cur();
        wait_queue_at(N - 2);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(1'b0);

        // Second matrix offered during STREAM must wait for out_last
        send_cur();
        randomize_cur();
        send_cur();
        drain(1'b0);

        // Reset after the fifth handshake aborts the stream
        load_plan();
        send_cur();
        wait_queue_at(N - 5);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", 32'(in_ready), 32'd1);
        randomize_cur();
        send_cur();
        drain(1'b0);

        // Random matrices with random backpressure
        for (int k = 0; k < 6; k++) begin
            randomize_cur();
            send_cur();
            drain(1'b1);
        end

        // 1x1 instance
        mat_in1   = 8'hA5;
        in_valid1 = 1'b1;
        @(negedge clk);
        check("one_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        mat_in1   = 8'h00;
        @(negedge clk);
        check("one_valid", 32'(out_valid1), 32'd1);
        check("one_data", 32'(out_data1), 32'hA5);
        check("one_row_col", 32'({out_row1, out_col1}), 32'b11);
        check("one_last", 32'(out_last1), 32'd1);
        check("one_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        check("one_idle_valid", 32'(out_valid1), 32'd0);
        check("one_idle_ready", 32'(in_ready1), 32'd1);
        check("one_idle_busy", 32'(busy1), 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
